// File: rtl/sp_ram_arbiter_if.sv
// Bus bundle between two masters, the sp_ram_arbiter and a single-port RAM.
// The arbiter uses the slave modport; the masters/RAM environment uses master.
interface sp_ram_arbiter_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  m0_req_i;
  logic                  m0_gnt_o;
  logic [ADDR_WIDTH-1:0] m0_addr_i;
  logic                  m0_we_i;
  logic [3:0]            m0_be_i;
  logic [31:0]           m0_wdata_i;
  logic                  m0_rvalid_o;
  logic [31:0]           m0_rdata_o;

  logic                  m1_req_i;
  logic                  m1_gnt_o;
  logic [ADDR_WIDTH-1:0] m1_addr_i;
  logic                  m1_we_i;
  logic [3:0]            m1_be_i;
  logic [31:0]           m1_wdata_i;
  logic                  m1_rvalid_o;
  logic [31:0]           m1_rdata_o;

  logic                  ram_en_o;
  logic                  ram_we_o;
  logic [ADDR_WIDTH-1:0] ram_addr_o;
  logic [3:0]            ram_be_o;
  logic [31:0]           ram_wdata_o;
  logic [31:0]           ram_rdata_i;

  modport slave (
    input  m0_req_i, m0_addr_i, m0_we_i, m0_be_i, m0_wdata_i,
    output m0_gnt_o, m0_rvalid_o, m0_rdata_o,
    input  m1_req_i, m1_addr_i, m1_we_i, m1_be_i, m1_wdata_i,
    output m1_gnt_o, m1_rvalid_o, m1_rdata_o,
    output ram_en_o, ram_we_o, ram_addr_o, ram_be_o, ram_wdata_o,
    input  ram_rdata_i
  );

  modport master (
    output m0_req_i, m0_addr_i, m0_we_i, m0_be_i, m0_wdata_i,
    input  m0_gnt_o, m0_rvalid_o, m0_rdata_o,
    output m1_req_i, m1_addr_i, m1_we_i, m1_be_i, m1_wdata_i,
    input  m1_gnt_o, m1_rvalid_o, m1_rdata_o,
    input  ram_en_o, ram_we_o, ram_addr_o, ram_be_o, ram_wdata_o,
    output ram_rdata_i
  );
endinterface

// File: rtl/sp_ram_arbiter.sv
// Two-master arbiter in front of a single-port RAM with one-cycle read latency.
// Define SP_RAM_ARBITER_RR_EN for round-robin contention; default is fixed priority (m0 wins).
module sp_ram_arbiter #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  sp_ram_arbiter_if.slave    bus
);

  logic gnt0;
  logic gnt1;
  logic resp_valid_q, resp_valid_d;
  logic resp_idx_q,   resp_idx_d;
`ifdef SP_RAM_ARBITER_RR_EN
  logic last_q, last_d;
`endif

  // Grant is purely combinational from this cycle's requests.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (bus.m0_req_i && bus.m1_req_i) begin
`ifdef SP_RAM_ARBITER_RR_EN
        gnt0 = last_q;
        gnt1 = ~last_q;
`else
        gnt0 = 1'b1;
`endif
      end else begin
        gnt0 = bus.m0_req_i;
        gnt1 = bus.m1_req_i;
      end
    end
  end

  always_comb begin
    bus.ram_en_o    = 1'b0;
    bus.ram_we_o    = 1'b0;
    bus.ram_addr_o  = '0;
    bus.ram_be_o    = '0;
    bus.ram_wdata_o = '0;
    if (gnt0) begin
      bus.ram_en_o    = 1'b1;
      bus.ram_we_o    = bus.m0_we_i;
      bus.ram_addr_o  = bus.m0_addr_i;
      bus.ram_be_o    = bus.m0_be_i;
      bus.ram_wdata_o = bus.m0_wdata_i;
    end else if (gnt1) begin
      bus.ram_en_o    = 1'b1;
      bus.ram_we_o    = bus.m1_we_i;
      bus.ram_addr_o  = bus.m1_addr_i;
      bus.ram_be_o    = bus.m1_be_i;
      bus.ram_wdata_o = bus.m1_wdata_i;
    end
  end

  always_comb begin
    resp_valid_d = gnt0 | gnt1;
    resp_idx_d   = gnt1;
`ifdef SP_RAM_ARBITER_RR_EN
    last_d = last_q;
    if (gnt0 || gnt1) begin
      last_d = gnt1;
    end
`endif
  end

  // Pointer resets to 1 so that m0 wins the first contention.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid_q <= 1'b0;
      resp_idx_q   <= 1'b0;
`ifdef SP_RAM_ARBITER_RR_EN
      last_q       <= 1'b1;
`endif
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_idx_q   <= resp_idx_d;
`ifdef SP_RAM_ARBITER_RR_EN
      last_q       <= last_d;
`endif
    end
  end

  // Masking with rst drops a response whose grant came just before reset.
  always_comb begin
    bus.m0_gnt_o    = gnt0;
    bus.m1_gnt_o    = gnt1;
    bus.m0_rvalid_o = resp_valid_q & ~resp_idx_q & ~rst;
    bus.m1_rvalid_o = resp_valid_q &  resp_idx_q & ~rst;
    bus.m0_rdata_o  = bus.m0_rvalid_o ? bus.ram_rdata_i : 32'h0;
    bus.m1_rdata_o  = bus.m1_rvalid_o ? bus.ram_rdata_i : 32'h0;
  end

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Testbench for sp_ram_arbiter: directed scenarios plus a randomized run against a
// behavioural arbiter/memory model. Honours SP_RAM_ARBITER_RR_EN like the design.
module tb_sp_ram_arbiter;
  localparam int AW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sp_ram_arbiter_if #(.ADDR_WIDTH(AW)) bus ();
  sp_ram_arbiter #(.ADDR_WIDTH(AW)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int n_compared = 0;
  int n_mismatched = 0;

  // Behavioural single-port RAM: write-first, read data one cycle after enable.
  logic [31:0] ram_mem [256];
  logic [31:0] ram_rdata = 32'h0;
  assign bus.ram_rdata_i = ram_rdata;

  function automatic logic [31:0] ram_merge(input logic [31:0] old, input logic [31:0] wd,
                                            input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (bus.ram_en_o) begin
      if (bus.ram_we_o) begin
        ram_mem[bus.ram_addr_o] <= ram_merge(ram_mem[bus.ram_addr_o], bus.ram_wdata_o, bus.ram_be_o);
        ram_rdata <= ram_merge(ram_mem[bus.ram_addr_o], bus.ram_wdata_o, bus.ram_be_o);
      end else begin
        ram_rdata <= ram_mem[bus.ram_addr_o];
      end
    end
  end

  task automatic drive(input logic r0, input logic we0, input logic [AW-1:0] a0, input logic [3:0] be0,
                       input logic [31:0] d0, input logic r1, input logic we1, input logic [AW-1:0] a1,
                       input logic [3:0] be1, input logic [31:0] d1);
    bus.m0_req_i = r0; bus.m0_we_i = we0; bus.m0_addr_i = a0; bus.m0_be_i = be0; bus.m0_wdata_i = d0;
    bus.m1_req_i = r1; bus.m1_we_i = we1; bus.m1_addr_i = a1; bus.m1_be_i = be1; bus.m1_wdata_i = d1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 8'h0, 4'h0, 32'h0, 1'b0, 1'b0, 8'h0, 4'h0, 32'h0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 1'b0, 8'h01, 4'hF, 32'h0, 1'b1, 1'b0, 8'h02, 4'hF, 32'h0);
    @(negedge clk);
    n_compared++; if (bus.m0_gnt_o !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_m0_gnt: got %b want 0", bus.m0_gnt_o); end
    n_compared++; if (bus.m1_gnt_o !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_m1_gnt: got %b want 0", bus.m1_gnt_o); end
    n_compared++; if (bus.ram_en_o !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_ram_en: got %b want 0", bus.ram_en_o); end
    next_cycle();
    rst = 1'b0;
    idle();
    @(negedge clk);
    n_compared++; if (bus.m0_rvalid_o !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_m0_rvalid: got %b want 0", bus.m0_rvalid_o); end
    n_compared++; if (bus.m1_rvalid_o !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_m1_rvalid: got %b want 0", bus.m1_rvalid_o); end
    n_compared++; if (bus.m0_rdata_o !== 32'h0) begin n_mismatched++; $display("[TB] FAIL reset_m0_rdata: got %h want 0", bus.m0_rdata_o); end
    n_compared++; if (bus.ram_addr_o !== 8'h0) begin n_mismatched++; $display("[TB] FAIL reset_ram_addr: got %h want 0", bus.ram_addr_o); end
    next_cycle();
  endtask

  task automatic test_single_read();
    drive(1'b1, 1'b1, 8'h10, 4'hF, 32'hDEADBEEF, 1'b0, 1'b0, 8'h0, 4'h0, 32'h0);
    next_cycle();
    idle();
    next_cycle();
    drive(1'b1, 1'b0, 8'h10, 4'h0, 32'h0, 1'b0, 1'b0, 8'h0, 4'h0, 32'h0);
    @(negedge clk);
    n_compared++; if (bus.m0_gnt_o !== 1'b1) begin n_mismatched++; $display("[TB] FAIL rd_m0_gnt: got %b want 1", bus.m0_gnt_o); end
    n_compared++; if (bus.ram_en_o !== 1'b1) begin n_mismatched++; $display("[TB] FAIL rd_ram_en: got %b want 1", bus.ram_en_o); end
    n_compared++; if (bus.ram_addr_o !== 8'h10) begin n_mismatched++; $display("[TB] FAIL rd_ram_addr: got %h want 10", bus.ram_addr_o); end
    n_compared++; if (bus.ram_we_o !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rd_ram_we: got %b want 0", bus.ram_we_o); end
    next_cycle();
    idle();
    @(negedge clk);
    n_compared++; if (bus.m0_rvalid_o !== 1'b1) begin n_mismatched++; $display("[TB] FAIL rd_m0_rvalid: got %b want 1", bus.m0_rvalid_o); end
    n_compared++; if (bus.m0_rdata_o !== 32'hDEADBEEF) begin n_mismatched++; $display("[TB] FAIL rd_m0_rdata: got %h want deadbeef", bus.m0_rdata_o); end
    n_compared++; if ({bus.m1_gnt_o, bus.m1_rvalid_o} !== 2'b00) begin n_mismatched++; $display("[TB] FAIL rd_m1_flags: got %b want 00", {bus.m1_gnt_o, bus.m1_rvalid_o}); end
    n_compared++; if (bus.m1_rdata_o !== 32'h0) begin n_mismatched++; $display("[TB] FAIL rd_m1_rdata: got %h want 0", bus.m1_rdata_o); end
    next_cycle();
  endtask

  task automatic test_byte_write();
    drive(1'b0, 1'b0, 8'h0, 4'h0, 32'h0, 1'b1, 1'b1, 8'h05, 4'hF, 32'hAAAAAAAA);
    next_cycle();
    drive(1'b0, 1'b0, 8'h0, 4'h0, 32'h0, 1'b1, 1'b1, 8'h05, 4'b0101, 32'h11223344);
    @(negedge clk);
    n_compared++; if (bus.m1_gnt_o !== 1'b1) begin n_mismatched++; $display("[TB] FAIL bw_m1_gnt: got %b want 1", bus.m1_gnt_o); end
    n_compared++; if (bus.ram_be_o !== 4'b0101) begin n_mismatched++; $display("[TB] FAIL bw_ram_be: got %b want 0101", bus.ram_be_o); end
    n_compared++; if (bus.ram_wdata_o !== 32'h11223344) begin n_mismatched++; $display("[TB] FAIL bw_ram_wdata: got %h want 11223344", bus.ram_wdata_o); end
    next_cycle();
    drive(1'b0, 1'b0, 8'h0, 4'h0, 32'h0, 1'b1, 1'b0, 8'h05, 4'h0, 32'h0);
    @(negedge clk);
    n_compared++; if (bus.m1_rvalid_o !== 1'b1) begin n_mismatched++; $display("[TB] FAIL bw_wr_rvalid: got %b want 1", bus.m1_rvalid_o); end
    n_compared++; if (bus.m1_gnt_o !== 1'b1) begin n_mismatched++; $display("[TB] FAIL bw_rd_gnt: got %b want 1", bus.m1_gnt_o); end
    next_cycle();
    idle();
    @(negedge clk);
    n_compared++; if (bus.m1_rvalid_o !== 1'b1) begin n_mismatched++; $display("[TB] FAIL bw_rd_rvalid: got %b want 1", bus.m1_rvalid_o); end
    n_compared++; if (bus.m1_rdata_o !== 32'hAA22AA44) begin n_mismatched++; $display("[TB] FAIL bw_rd_rdata: got %h want aa22aa44", bus.m1_rdata_o); end
    n_compared++; if (bus.m0_rvalid_o !== 1'b0) begin n_mismatched++; $display("[TB] FAIL bw_m0_rvalid: got %b want 0", bus.m0_rvalid_o); end
    next_cycle();
  endtask

  task automatic test_contention();
    int win_seq[5];
`ifdef SP_RAM_ARBITER_RR_EN
    win_seq = '{0, 1, 0, 1, 1};
`else
    win_seq = '{0, 0, 0, 0, 1};
`endif
    do_reset();
    for (int c = 0; c < 6; c++) begin
      if (c < 4) drive(1'b1, 1'b0, 8'(c), 4'h0, 32'h0, 1'b1, 1'b0, 8'(c + 8), 4'h0, 32'h0);
      else if (c == 4) drive(1'b0, 1'b0, 8'h0, 4'h0, 32'h0, 1'b1, 1'b0, 8'h20, 4'h0, 32'h0);
      else idle();
      @(negedge clk);
      if (c < 5) begin
        n_compared++;
        if ({bus.m1_gnt_o, bus.m0_gnt_o} !== (win_seq[c] == 1 ? 2'b10 : 2'b01)) begin
          n_mismatched++;
          $display("[TB] FAIL contention_gnt[%0d]: got m1,m0=%b want winner m%0d", c, {bus.m1_gnt_o, bus.m0_gnt_o}, win_seq[c]);
        end
      end
      if (c > 0) begin
        n_compared++;
        if ({bus.m1_rvalid_o, bus.m0_rvalid_o} !== (win_seq[c-1] == 1 ? 2'b10 : 2'b01)) begin
          n_mismatched++;
          $display("[TB] FAIL contention_rvalid[%0d]: got m1,m0=%b want m%0d", c, {bus.m1_rvalid_o, bus.m0_rvalid_o}, win_seq[c-1]);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(1'b1, 1'b0, 8'h10, 4'h0, 32'h0, 1'b0, 1'b0, 8'h0, 4'h0, 32'h0);
    @(negedge clk);
    n_compared++; if (bus.m0_gnt_o !== 1'b1) begin n_mismatched++; $display("[TB] FAIL rmid_gnt_k: got %b want 1", bus.m0_gnt_o); end
    next_cycle();
    rst = 1'b1;
    idle();
    @(negedge clk);
    n_compared++; if (bus.m0_rvalid_o !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rmid_rvalid_k1: got %b want 0", bus.m0_rvalid_o); end
    n_compared++; if (bus.m0_rdata_o !== 32'h0) begin n_mismatched++; $display("[TB] FAIL rmid_rdata_k1: got %h want 0", bus.m0_rdata_o); end
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    n_compared++; if (bus.m0_rvalid_o !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rmid_rvalid_k2: got %b want 0", bus.m0_rvalid_o); end
    next_cycle();
    drive(1'b1, 1'b0, 8'h01, 4'h0, 32'h0, 1'b1, 1'b0, 8'h02, 4'h0, 32'h0);
    @(negedge clk);
    n_compared++; if ({bus.m1_gnt_o, bus.m0_gnt_o} !== 2'b01) begin n_mismatched++; $display("[TB] FAIL rmid_first_contention: got m1,m0=%b want 01", {bus.m1_gnt_o, bus.m0_gnt_o}); end
    next_cycle();
    idle();
    next_cycle();
  endtask

  task automatic test_withdraw();
    do_reset();
    drive(1'b1, 1'b0, 8'h03, 4'h0, 32'h0, 1'b1, 1'b1, 8'h03, 4'hF, 32'h12345678);
    @(negedge clk);
    n_compared++; if ({bus.m1_gnt_o, bus.m0_gnt_o} !== 2'b01) begin n_mismatched++; $display("[TB] FAIL wd_gnt: got m1,m0=%b want 01", {bus.m1_gnt_o, bus.m0_gnt_o}); end
    next_cycle();
    idle();
    @(negedge clk);
    n_compared++; if ({bus.m1_gnt_o, bus.m1_rvalid_o} !== 2'b00) begin n_mismatched++; $display("[TB] FAIL wd_m1_c2: got gnt,rvalid=%b want 00", {bus.m1_gnt_o, bus.m1_rvalid_o}); end
    n_compared++; if (bus.m0_rvalid_o !== 1'b1) begin n_mismatched++; $display("[TB] FAIL wd_m0_rvalid: got %b want 1", bus.m0_rvalid_o); end
    next_cycle();
    @(negedge clk);
    n_compared++; if (bus.m1_rvalid_o !== 1'b0) begin n_mismatched++; $display("[TB] FAIL wd_m1_c3: got %b want 0", bus.m1_rvalid_o); end
    next_cycle();
  endtask

  // Reference: winner from the arbitration rules, a word array with byte-masked writes.
  task automatic test_random();
    logic [31:0] model_mem [8];
    int          model_last;
    bit          pend_valid;
    int          pend_idx;
    logic [31:0] pend_data;
    logic        r0, r1, we0, we1;
    logic [AW-1:0] a0, a1;
    logic [3:0]  be0, be1;
    logic [31:0] d0, d1, mask, exp_wd;
    int          win;
    logic [AW-1:0] exp_addr;
    logic [3:0]  exp_be;
    logic        exp_we;
    do_reset();
    model_last = 1;
    pend_valid = 1'b0;
    pend_idx = 0;
    pend_data = 32'h0;
    for (int c = 0; c < 400; c++) begin
      if (c < 8) begin
        r0 = 1'b1; we0 = 1'b1; a0 = 8'(c); be0 = 4'hF; d0 = $urandom;
        r1 = 1'b0; we1 = 1'b0; a1 = 8'h0; be1 = 4'h0; d1 = 32'h0;
      end else begin
        r0 = ($urandom_range(0, 9) < 6); we0 = $urandom_range(0, 1) == 1; a0 = 8'($urandom_range(0, 7));
        be0 = 4'($urandom_range(0, 15)); d0 = $urandom;
        r1 = ($urandom_range(0, 9) < 6); we1 = $urandom_range(0, 1) == 1; a1 = 8'($urandom_range(0, 7));
        be1 = 4'($urandom_range(0, 15)); d1 = $urandom;
      end
      drive(r0, we0, a0, be0, d0, r1, we1, a1, be1, d1);
      if (r0 && r1) begin
`ifdef SP_RAM_ARBITER_RR_EN
        win = 1 - model_last;
`else
        win = 0;
`endif
      end else if (r0) win = 0;
      else if (r1) win = 1;
      else win = -1;
      exp_addr = (win == 0) ? a0 : (win == 1) ? a1 : 8'h0;
      exp_we   = (win == 0) ? we0 : (win == 1) ? we1 : 1'b0;
      exp_be   = (win == 0) ? be0 : (win == 1) ? be1 : 4'h0;
      exp_wd   = (win == 0) ? d0 : (win == 1) ? d1 : 32'h0;
      @(negedge clk);
      n_compared++; if (bus.m0_gnt_o !== (win == 0)) begin n_mismatched++; $display("[TB] FAIL rnd_m0_gnt[%0d]: got %b want %b", c, bus.m0_gnt_o, win == 0); end
      n_compared++; if (bus.m1_gnt_o !== (win == 1)) begin n_mismatched++; $display("[TB] FAIL rnd_m1_gnt[%0d]: got %b want %b", c, bus.m1_gnt_o, win == 1); end
      n_compared++; if (bus.ram_en_o !== (win >= 0)) begin n_mismatched++; $display("[TB] FAIL rnd_ram_en[%0d]: got %b want %b", c, bus.ram_en_o, win >= 0); end
      n_compared++;
      if ({bus.ram_addr_o, bus.ram_we_o, bus.ram_be_o, bus.ram_wdata_o} !== {exp_addr, exp_we, exp_be, exp_wd}) begin
        n_mismatched++;
        $display("[TB] FAIL rnd_ram_fields[%0d]: got a=%h we=%b be=%h wd=%h want a=%h we=%b be=%h wd=%h", c,
                 bus.ram_addr_o, bus.ram_we_o, bus.ram_be_o, bus.ram_wdata_o, exp_addr, exp_we, exp_be, exp_wd);
      end
      n_compared++; if (bus.m0_rvalid_o !== (pend_valid && pend_idx == 0)) begin n_mismatched++; $display("[TB] FAIL rnd_m0_rvalid[%0d]: got %b", c, bus.m0_rvalid_o); end
      n_compared++; if (bus.m1_rvalid_o !== (pend_valid && pend_idx == 1)) begin n_mismatched++; $display("[TB] FAIL rnd_m1_rvalid[%0d]: got %b", c, bus.m1_rvalid_o); end
      n_compared++; if (bus.m0_rdata_o !== ((pend_valid && pend_idx == 0) ? pend_data : 32'h0)) begin n_mismatched++; $display("[TB] FAIL rnd_m0_rdata[%0d]: got %h want %h", c, bus.m0_rdata_o, (pend_valid && pend_idx == 0) ? pend_data : 32'h0); end
      n_compared++; if (bus.m1_rdata_o !== ((pend_valid && pend_idx == 1) ? pend_data : 32'h0)) begin n_mismatched++; $display("[TB] FAIL rnd_m1_rdata[%0d]: got %h want %h", c, bus.m1_rdata_o, (pend_valid && pend_idx == 1) ? pend_data : 32'h0); end
      if (win >= 0) begin
        if (exp_we) begin
          mask = {{8{exp_be[3]}}, {8{exp_be[2]}}, {8{exp_be[1]}}, {8{exp_be[0]}}};
          model_mem[exp_addr[2:0]] = (model_mem[exp_addr[2:0]] & ~mask) | (exp_wd & mask);
        end
        pend_valid = 1'b1;
        pend_idx   = win;
        pend_data  = model_mem[exp_addr[2:0]];
        model_last = win;
      end else begin
        pend_valid = 1'b0;
      end
      next_cycle();
    end
    idle();
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_byte_write();
    test_contention();
    test_reset_mid();
    test_withdraw();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
